// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin scheduler sharing one UART transmit line between NUM_REQ requesters.
// A granted word is latched and serialised as one start bit, DATA_WIDTH data bits
// (LSB first), and STOP_BITS stop bits. Each bit is BAUD_COUNT clk cycles long, and
// bit boundaries come from an internal baud counter.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   tx_enable_i   gates new grants; a frame already in flight always completes
//   req_valid_i   per-requester word available
//   req_data_i    requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o   one-hot accept, combinational, only in the grant cycle
//   txd_o         serial output, idle high
//   busy_o        high for every cycle of a frame
//   grant_id_o    index of the requester owning the current frame
//   frame_done_o  single-cycle pulse in the last cycle of the final stop bit
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ            = 4,
    parameter int unsigned DATA_WIDTH         = 9,
    parameter int unsigned BAUD_COUNT         = 5,
    parameter int unsigned BAUD_COUNTER_WIDTH = 9,
    parameter int unsigned STOP_BITS          = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_enable_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [2:0]                    grant_id_o,
    output logic                          frame_done_o
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                        state_q;
    logic [DATA_WIDTH-1:0]         shift_q;
    logic [DATA_WIDTH-1:0]         shift_nxt;
    logic [BitCntW-1:0]            bit_cnt_q;
    logic [0:0]                    stop_cnt_q;
    logic                          txd_q;
    logic                          busy_q;
    logic [2:0]                    grant_id_q;
    logic                          frame_done_q;
    logic [2:0]                    ptr_q;
    logic [2:0]                    ptr_next;

    logic                          found;
    logic [2:0]                    winner;
    logic [DATA_WIDTH-1:0]         win_data;
    logic                          grant;

    logic [BAUD_COUNTER_WIDTH-1:0] baud_cnt_q;
    logic                          reset_counters;
    logic                          baud_tick;
    logic                          stop_last;

    // Round-robin search: first pass takes the lowest valid index at or above the
    // pointer; if none, the second pass takes the lowest valid index overall, which
    // is exactly the wrap-around part of the ascending search.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i] && (ptr_q <= 3'(i))) begin
                found    = 1'b1;
                winner   = 3'(i);
                win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i]) begin
                found    = 1'b1;
                winner   = 3'(i);
                win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant          = (state_q == StIdle) && tx_enable_i && found && !reset;
    assign ptr_next       = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
    assign req_ready_o    = grant ? (NUM_REQ'(1) << winner) : '0;
    assign shift_nxt      = shift_q >> 1;

    // Baud counter: cleared on the grant cycle so the start bit is always a full
    // BAUD_COUNT cycles; baud_tick marks the last cycle of each bit period.
    assign reset_counters = grant;
    assign baud_tick      = (baud_cnt_q == BAUD_COUNTER_WIDTH'(BAUD_COUNT - 1));
    assign stop_last      = (stop_cnt_q == 1'(STOP_BITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_q <= '0;
        end else if (reset_counters || baud_tick) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= '0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            frame_done_q <= 1'b0;
            ptr_q        <= '0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q    <= StStart;
                        shift_q    <= win_data;
                        grant_id_q <= winner;
                        ptr_q      <= ptr_next;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= '0;
                        txd_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StStart: begin
                    if (baud_tick) begin
                        state_q <= StData;
                        txd_q   <= shift_q[0];
                    end
                end
                StData: begin
                    if (baud_tick) begin
                        shift_q <= shift_nxt;
                        if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                            state_q <= StStop;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                            txd_q     <= shift_nxt[0];
                        end
                    end
                end
                StStop: begin
                    // Registered pulse: raise one cycle ahead so it lands on the
                    // final cycle of the last stop bit.
                    if (stop_last && (baud_cnt_q == BAUD_COUNTER_WIDTH'(BAUD_COUNT - 2))) begin
                        frame_done_q <= 1'b1;
                    end
                    if (baud_tick) begin
                        if (stop_last) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign grant_id_o   = grant_id_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: single frame, round-robin order, skip and
// wrap, tx_enable gating, mid-frame reset, and a two-stop-bit instance.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_enable;
    logic [3:0]  req_valid;
    logic [35:0] req_data;
    logic [3:0]  req_ready;
    logic        txd;
    logic        busy;
    logic [2:0]  grant_id;
    logic        frame_done;

    logic        tx_enable2;
    logic [3:0]  req_valid2;
    logic [35:0] req_data2;
    logic [3:0]  req_ready2;
    logic        txd2;
    logic        busy2;
    logic [2:0]  grant_id2;
    logic        frame_done2;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [8:0] words [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tx_enable_i  (tx_enable),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .txd_o        (txd),
        .busy_o       (busy),
        .grant_id_o   (grant_id),
        .frame_done_o (frame_done)
    );

    uart_tx_scheduler #(.STOP_BITS(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .tx_enable_i  (tx_enable2),
        .req_valid_i  (req_valid2),
        .req_data_i   (req_data2),
        .req_ready_o  (req_ready2),
        .txd_o        (txd2),
        .busy_o       (busy2),
        .grant_id_o   (grant_id2),
        .frame_done_o (frame_done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        tx_enable = 1'b0;
        req_valid = 4'b0000;
        tick();
        tick();
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b0;
    endtask

    // Returns the granted index and the grant cycle, leaving the bench in cycle t+1.
    task automatic wait_grant(output int g, output int at);
        g  = -1;
        at = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != 4'b0000) begin
                check("ready_onehot", 32'($onehot(req_ready)), 1);
                for (int j = 0; j < 4; j++) if (req_ready[j]) g = j;
                at = cyc;
                tick();
                return;
            end
            tick();
        end
        check("grant_timeout", 0, 1);
    endtask

    // Checks cycles t+1..t+55 of a frame and the idle cycle t+56.
    task automatic check_frame(input logic [8:0] data, input int gid, input int drop_at);
        logic [10:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int c = 1; c <= 55; c++) begin
            if (c == drop_at) tx_enable = 1'b0;
            check("txd", txd, bits[(c-1)/5]);
            check("busy", busy, 1);
            check("frame_done", frame_done, (c == 55) ? 1 : 0);
            check("ready_while_busy", req_ready, 0);
            check("grant_id", grant_id, gid);
            tick();
        end
        check("end_busy", busy, 0);
        check("end_txd", txd, 1);
    endtask

    initial begin
        int g;
        int t;
        int prev;
        int en_at;

        words[0] = 9'h1A5;
        words[1] = 9'h0F3;
        words[2] = 9'h12C;
        words[3] = 9'h055;
        tx_enable2 = 1'b0;
        req_valid2 = 4'b0000;
        req_data2  = '0;
        req_data   = '0;

        // Single word 0x1A5 from requester 0; payload scrambled after acceptance.
        do_reset();
        tx_enable     = 1'b1;
        req_data[8:0] = 9'h1A5;
        req_valid     = 4'b0001;
        wait_grant(g, t);
        check("single_gid", g, 0);
        req_valid = 4'b0000;
        req_data  = '1;
        check_frame(9'h1A5, 0, 0);

        // Round-robin with all four requesters valid, back-to-back frames.
        do_reset();
        req_data  = {words[3], words[2], words[1], words[0]};
        req_valid = 4'b1111;
        tx_enable = 1'b1;
        prev      = 0;
        for (int k = 0; k < 8; k++) begin
            wait_grant(g, t);
            check("rr_order", g, k % 4);
            if (k > 0) check("rr_gap", t - prev, 56);
            prev = t;
            check_frame(words[k%4], k % 4, 0);
        end

        // Skip and wrap: pointer at 2 after granting 1, so 0 wins, then 1.
        do_reset();
        tx_enable = 1'b1;
        req_valid = 4'b0010;
        wait_grant(g, t);
        check("skip_first", g, 1);
        req_valid = 4'b0011;
        check_frame(words[1], 1, 0);
        wait_grant(g, t);
        check("skip_wrap", g, 0);
        check_frame(words[0], 0, 0);
        wait_grant(g, t);
        check("skip_then", g, 1);
        check_frame(words[1], 1, 0);

        // tx_enable dropped mid-frame; requester 2 withdraws before re-enable.
        do_reset();
        tx_enable = 1'b1;
        req_valid = 4'b0001;
        wait_grant(g, t);
        check("en_first", g, 0);
        check_frame(words[0], 0, 10);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) req_valid = 4'b0101;
            #1;
            check("ready_disabled", req_ready, 0);
            tick();
        end
        req_valid = 4'b1001;
        tx_enable = 1'b1;
        en_at     = cyc;
        wait_grant(g, t);
        check("en_winner", g, 3);
        check("en_same_cycle", t, en_at);
        check_frame(words[3], 3, 0);

        // Reset 20 cycles into a frame from requester 2.
        do_reset();
        tx_enable = 1'b1;
        req_valid = 4'b0100;
        wait_grant(g, t);
        check("mid_rst_gid", g, 2);
        for (int i = 0; i < 19; i++) tick();
        check("mid_rst_busy_before", busy, 1);
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        check("mid_rst_txd", txd, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_grant_id", grant_id, 0);
        reset     = 1'b0;
        req_valid = 4'b0101;
        wait_grant(g, t);
        check("post_rst_winner", g, 0);
        req_valid = 4'b0000;
        check_frame(words[0], 0, 0);

        // Two stop bits, all-zero payload.
        tx_enable2 = 1'b1;
        req_valid2 = 4'b0001;
        #1;
        check("sb2_ready", req_ready2, 1);
        tick();
        req_valid2 = 4'b0000;
        for (int c = 1; c <= 60; c++) begin
            check("sb2_txd", txd2, (c <= 50) ? 0 : 1);
            check("sb2_busy", busy2, 1);
            check("sb2_frame_done", frame_done2, (c == 60) ? 1 : 0);
            tick();
        end
        check("sb2_end_busy", busy2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
